// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: pulses pll_rst, waits for a settled lock with timeout
// and bounded retries, then releases sys_rst and watches for lock loss.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 1000000,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 7
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               ready,
   output logic                               fault,
   output logic                               lost_lock,
   output logic [$clog2(MAX_RETRIES+2)-1:0]   retry_count
);

   localparam int RC_W = $clog2(MAX_RETRIES + 2);
   localparam int PR_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
   localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_SETTLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t state_reg, state_next;

   logic [PR_W-1:0] pr_cnt_reg, pr_cnt_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next, to_cnt_inc;
   logic [ST_W-1:0] st_cnt_reg, st_cnt_next;
   logic [RC_W-1:0] retry_reg, retry_next;

   logic pll_rst_reg, sys_rst_reg, ready_reg, fault_reg, lost_lock_reg;
   logic lost_lock_next;
   logic failure;

   // The raw PLL lock is only ever seen through this chain.
   logic [SYNC_STAGES-1:0] sync_reg, sync_next;
   logic                   lock_s;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = pll_locked;
         end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   assign lock_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign to_cnt_inc = (to_cnt_reg == TO_LAST) ? to_cnt_reg : to_cnt_reg + TO_W'(1);

   always_comb begin
      state_next     = state_reg;
      pr_cnt_next    = pr_cnt_reg;
      to_cnt_next    = to_cnt_reg;
      st_cnt_next    = st_cnt_reg;
      retry_next     = retry_reg;
      lost_lock_next = 1'b0;
      failure        = 1'b0;

      case (state_reg)
         S_PLL_RST: begin
            if (pr_cnt_reg == PR_LAST) begin
               state_next = S_WAIT_LOCK;
            end else begin
               pr_cnt_next = pr_cnt_reg + PR_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            to_cnt_next = to_cnt_inc;
            if (lock_s) begin
               state_next  = S_SETTLE;
               st_cnt_next = '0;
            end else if (to_cnt_reg == TO_LAST) begin
               failure = 1'b1;
            end
         end
         S_SETTLE: begin
            // Timeout keeps running so a flapping lock cannot stall here forever.
            to_cnt_next = to_cnt_inc;
            if (!lock_s) begin
               if (to_cnt_reg == TO_LAST) begin
                  failure = 1'b1;
               end else begin
                  state_next = S_WAIT_LOCK;
               end
            end else if (st_cnt_reg == ST_LAST) begin
               state_next = S_RUN;
            end else begin
               st_cnt_next = st_cnt_reg + ST_W'(1);
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               lost_lock_next = 1'b1;
               failure        = 1'b1;
            end
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_FAULT;
         end
      endcase

      if (failure) begin
         if (retry_reg == RC_MAX) begin
            state_next = S_FAULT;
         end else begin
            retry_next = retry_reg + RC_W'(1);
            state_next = S_PLL_RST;
         end
      end

      if (state_next == S_PLL_RST && state_reg != S_PLL_RST) begin
         pr_cnt_next = '0;
         to_cnt_next = '0;
      end

      if (state_next == S_RUN && state_reg != S_RUN) begin
         retry_next = '0;
      end
   end

   // Outputs are decoded from the next state so they change together with state_reg.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_reg     <= S_PLL_RST;
         pr_cnt_reg    <= '0;
         to_cnt_reg    <= '0;
         st_cnt_reg    <= '0;
         retry_reg     <= '0;
         pll_rst_reg   <= 1'b1;
         sys_rst_reg   <= 1'b1;
         ready_reg     <= 1'b0;
         fault_reg     <= 1'b0;
         lost_lock_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pr_cnt_reg    <= pr_cnt_next;
         to_cnt_reg    <= to_cnt_next;
         st_cnt_reg    <= st_cnt_next;
         retry_reg     <= retry_next;
         pll_rst_reg   <= (state_next == S_PLL_RST);
         sys_rst_reg   <= (state_next != S_RUN);
         ready_reg     <= (state_next == S_RUN);
         fault_reg     <= (state_next == S_FAULT);
         lost_lock_reg <= lost_lock_next;
      end
   end

   assign pll_rst     = pll_rst_reg;
   assign sys_rst     = sys_rst_reg;
   assign ready       = ready_reg;
   assign fault       = fault_reg;
   assign lost_lock   = lost_lock_reg;
   assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Cycle n is the clock period after the n-th edge following the last rst-high edge.
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic       lost_lock;
   logic [1:0] retry_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES   (2),
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (100),
      .SETTLE_CYCLES (8),
      .MAX_RETRIES   (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .lost_lock  (lost_lock),
      .retry_count(retry_count)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      int cyc;      // cycle at which outputs are checked
      bit lock;     // pll_locked driven from this cycle on
      bit p_rst;
      bit s_rst;
      bit rdy;
      bit flt;
      bit lost;
      int rc;
   } vec_t;

   vec_t tbl[15];

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic goto_cycle(input int n);
      while (cyc < n) step();
   endtask

   // Leaves rst low with the bench in cycle 0.
   task automatic do_reset();
      rst        = 1'b1;
      pll_locked = 1'b0;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input bit p, input bit s, input bit r,
                          input bit f, input bit l, input int rc);
      chk({tag, ".pll_rst"},     int'(pll_rst),     int'(p));
      chk({tag, ".sys_rst"},     int'(sys_rst),     int'(s));
      chk({tag, ".ready"},       int'(ready),       int'(r));
      chk({tag, ".fault"},       int'(fault),       int'(f));
      chk({tag, ".lost_lock"},   int'(lost_lock),   int'(l));
      chk({tag, ".retry_count"}, int'(retry_count), rc);
      $display("%s cyc=%0d pll_rst=%0b sys_rst=%0b ready=%0b fault=%0b lost=%0b rc=%0d",
               tag, cyc, pll_rst, sys_rst, ready, fault, lost_lock, retry_count);
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;

      // Nominal bring-up followed by lock loss in RUN and relock.
      //          cyc lock p  s  r  f  l  rc
      tbl[0]  = '{  0, 0, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{  3, 0, 1, 1, 0, 0, 0, 0};
      tbl[2]  = '{  4, 0, 0, 1, 0, 0, 0, 0};
      tbl[3]  = '{ 20, 1, 0, 1, 0, 0, 0, 0};
      tbl[4]  = '{ 30, 1, 0, 1, 0, 0, 0, 0};
      tbl[5]  = '{ 31, 1, 0, 0, 1, 0, 0, 0};
      tbl[6]  = '{ 40, 0, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{ 42, 0, 0, 0, 1, 0, 0, 0};
      tbl[8]  = '{ 43, 0, 1, 1, 0, 0, 1, 1};
      tbl[9]  = '{ 44, 0, 1, 1, 0, 0, 0, 1};
      tbl[10] = '{ 46, 0, 1, 1, 0, 0, 0, 1};
      tbl[11] = '{ 47, 0, 0, 1, 0, 0, 0, 1};
      tbl[12] = '{ 50, 1, 0, 1, 0, 0, 0, 1};
      tbl[13] = '{ 60, 1, 0, 1, 0, 0, 0, 1};
      tbl[14] = '{ 61, 1, 0, 0, 1, 0, 0, 0};

      // Outputs while rst is held.
      step();
      step();
      chk_out("in_reset", 1, 1, 0, 0, 0, 0);

      do_reset();
      for (int i = 0; i < 15; i++) begin
         goto_cycle(tbl[i].cyc);
         chk_out($sformatf("vec%0d", i), tbl[i].p_rst, tbl[i].s_rst, tbl[i].rdy,
                 tbl[i].flt, tbl[i].lost, tbl[i].rc);
         pll_locked = tbl[i].lock;
      end

      // One-cycle rst while in RUN, lock still present.
      rst = 1'b1;
      step();
      chk_out("rst_in_run", 1, 1, 0, 0, 0, 0);
      rst = 1'b0;
      cyc = 0;
      goto_cycle(3);
      chk_out("rerun_c3", 1, 1, 0, 0, 0, 0);
      goto_cycle(4);
      chk_out("rerun_c4", 0, 1, 0, 0, 0, 0);
      goto_cycle(12);
      chk_out("rerun_c12", 0, 1, 0, 0, 0, 0);
      goto_cycle(13);
      chk_out("rerun_c13", 0, 0, 1, 0, 0, 0);

      // Lock never arrives: two retries then fault.
      do_reset();
      goto_cycle(103);
      chk_out("nolock_c103", 0, 1, 0, 0, 0, 0);
      goto_cycle(104);
      chk_out("nolock_c104", 1, 1, 0, 0, 0, 1);
      goto_cycle(207);
      chk_out("nolock_c207", 0, 1, 0, 0, 0, 1);
      goto_cycle(208);
      chk_out("nolock_c208", 1, 1, 0, 0, 0, 2);
      goto_cycle(311);
      chk_out("nolock_c311", 0, 1, 0, 0, 0, 2);
      goto_cycle(312);
      chk_out("nolock_c312", 0, 1, 0, 1, 0, 2);
      goto_cycle(420);
      chk_out("fault_hold", 0, 1, 0, 1, 0, 2);

      // One-cycle rst while in FAULT.
      rst = 1'b1;
      step();
      chk_out("rst_in_fault", 1, 1, 0, 0, 0, 0);
      rst = 1'b0;

      // One-cycle lock glitch during SETTLE restarts the settle count.
      do_reset();
      goto_cycle(20);
      pll_locked = 1'b1;
      goto_cycle(25);
      pll_locked = 1'b0;
      goto_cycle(26);
      pll_locked = 1'b1;
      goto_cycle(31);
      chk_out("glitch_c31", 0, 1, 0, 0, 0, 0);
      goto_cycle(36);
      chk_out("glitch_c36", 0, 1, 0, 0, 0, 0);
      goto_cycle(37);
      chk_out("glitch_c37", 0, 0, 1, 0, 0, 0);

      // Synced lock arrives on the very cycle the timeout expires.
      do_reset();
      goto_cycle(101);
      pll_locked = 1'b1;
      goto_cycle(103);
      chk_out("edge_c103", 0, 1, 0, 0, 0, 0);
      goto_cycle(104);
      chk_out("edge_c104", 0, 1, 0, 0, 0, 0);
      goto_cycle(111);
      chk_out("edge_c111", 0, 1, 0, 0, 0, 0);
      goto_cycle(112);
      chk_out("edge_c112", 0, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
